icx_spi_slave: RTL and testbench
================================

Name: icx_spi_slave

Overview:
- Write-only SPI responder in the channel FPGA. It terminates the ICX serial link driven by the main FPGA's SPI master on ICX[2] (CS), ICX[3] (data) and ICX[4] (clock), with clock polarity 0.
- It deserialises 16-bit frames into register writes: 4-bit address and 12-bit data.
- It holds a 16 x 12-bit control register bank and counts malformed frames.
- It runs entirely on wb_clk and oversamples the SPI lines.

Parameters:
- NSYNC, 2, number of synchroniser flops on spi_clk, spi_cs and spi_dat (minimum 2).
- REG_INIT, 12'h000, reset value of every register in the bank.

Ports:
- wb_clk  input  1  system clock; all logic is on its rising edge.
- wb_rst  input  1  reset, asynchronous, active-low.
- spi_clk  input  1  SPI clock from the master; idles low.
- spi_cs  input  1  chip select, active-low.
- spi_dat  input  1  serial data, MSB first.
- reg_wr  output  1  one-cycle strobe per accepted word.
- reg_adr  output  4  address of the last accepted word.
- reg_dat  output  12  data of the last accepted word.
- regs_o  output  192  register bank, flattened; register k occupies bits [12k+11:12k].
- frame_err  output  1  one-cycle strobe on a malformed frame.
- err_cnt  output  8  saturating count of malformed frames.

Behaviour:
- Reset (wb_rst=0, asynchronous):
  - reg_wr=0, frame_err=0, reg_adr=0, reg_dat=0, err_cnt=0.
  - All registers in the bank = REG_INIT.
  - Shift register cleared, bit counter = 0, state = IDLE.
  - Synchroniser flops are set to their idle levels: spi_clk=0, spi_cs=1, spi_dat=0.
- Synchronisation:
  - Each input passes through NSYNC flops.
  - Edges are detected by comparing the last synchroniser stage with one extra delay flop.
  - Timing requirement: spi_clk high time and low time ≥ 4 wb_clk cycles each. Nominal operation is about 2 MHz SPI against about 208 MHz wb_clk.
- States: IDLE, SHIFT.
  - IDLE → SHIFT on a synchronised spi_cs falling edge. Bit counter is set to 0 and the shift register is cleared.
  - In SHIFT, on each synchronised spi_clk rising edge, shift in spi_dat (MSB first) and increment the bit counter (4-bit plus wrap flag).
  - When the 16th bit is shifted in:
    - commit word: reg_adr=sr[15:12], reg_dat=sr[11:0], regs_o[reg_adr]=reg_dat;
    - assert reg_wr for exactly one cycle, on the cycle after the edge-detect cycle;
    - reset the counter to 0 and stay in SHIFT, so bursts of several words under one CS are legal.
  - SHIFT → IDLE on a synchronised spi_cs rising edge:
    - bit counter = 0: clean end of frame, no action;
    - bit counter ≠ 0: partial word is discarded, frame_err pulses for one cycle, err_cnt increments and saturates at 8'hFF.
  - spi_clk edges while in IDLE are ignored.
- Latency: from spi_clk rising at the pin (16th bit) to reg_wr high = NSYNC+2 wb_clk cycles (4 with the default NSYNC).
- Simultaneous events: if the 16th-bit spi_clk edge and the spi_cs rising edge are detected in the same cycle:
  - the word is committed (reg_wr=1);
  - no frame_err is raised;
  - the state returns to IDLE.
- Write to a register already holding the same value: still produces reg_wr.
- Reset during SHIFT: the partial word is lost, no reg_wr and no err_cnt change. After release the block waits in IDLE for a fresh spi_cs falling edge; a CS already held low at release is not treated as a frame start.

Test Plan:
- Reset → regs_o all 12'h000, err_cnt=0. Single frame 16'h3ABC → reg_wr for 1 cycle 4 cycles after the last spi_clk rise, reg_adr=3, reg_dat=12'hABC, regs_o[47:36]=12'hABC, no other register changes.
- Burst under one CS of 16'h0001, 16'hF123, 16'h7FFF → three reg_wr pulses; reg0=12'h001, reg15=12'h123, reg7=12'hFFF; err_cnt stays 0.
- CS raised after 9 bits of 16'h5555 → no reg_wr, frame_err pulses once, err_cnt=1, reg5 unchanged. A following good frame 16'h5555 gives reg5=12'h555.
- 300 consecutive 5-bit frames → err_cnt saturates at 8'hFF and does not wrap. A following good frame is still accepted.
- CS rise detected in the same cycle as the 16th spi_clk edge of 16'h2010 → reg2=12'h010, reg_wr=1, frame_err=0.
- wb_rst asserted after bit 8 of a frame, released while CS still low, remaining bits clocked → no reg_wr, no frame_err. The next full frame after a fresh CS falling edge is accepted correctly.

Source files
------------

// File: rtl/icx_spi_slave.sv
// Write-only SPI (mode 0) responder on the ICX link: oversamples the SPI lines on wb_clk,
// turns 16-bit frames {addr[3:0], data[11:0]} into register writes and counts malformed frames.
module icx_spi_slave #(
  parameter int         NSYNC    = 2,
  parameter logic [11:0] REG_INIT = 12'h000
) (
  input  logic         wb_clk,
  input  logic         wb_rst,
  input  logic         spi_clk,
  input  logic         spi_cs,
  input  logic         spi_dat,
  output logic         reg_wr,
  output logic [3:0]   reg_adr,
  output logic [11:0]  reg_dat,
  output logic [191:0] regs_o,
  output logic         frame_err,
  output logic [7:0]   err_cnt
);

  localparam int NS   = (NSYNC < 2) ? 2 : NSYNC;
  localparam int WARM = NS + 2;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;

  logic [NS-1:0]   r_clk_sync;
  logic [NS-1:0]   r_cs_sync;
  logic [NS-1:0]   r_dat_sync;
  logic [WARM-1:0] r_warm;
  logic            r_armed;
  logic            r_clk_d;
  logic            r_cs_d;
  logic            r_clk_rise;
  logic            r_cs_rise;
  logic            r_cs_fall;
  logic            r_dat_q;

  state_t          r_state;
  state_t          w_nxt_state;
  logic [14:0]     r_sr;
  logic [14:0]     w_nxt_sr;
  logic [15:0]     w_sr_shift;
  logic [3:0]      r_cnt;
  logic [3:0]      w_nxt_cnt;
  logic            w_commit;
  logic            w_err;

  logic            r_reg_wr;
  logic            r_frame_err;
  logic [3:0]      r_reg_adr;
  logic [11:0]     r_reg_dat;
  logic [7:0]      r_err_cnt;
  logic [11:0]     r_regs [16];

  logic            w_clk_last;
  logic            w_cs_last;
  logic            w_dat_last;

  assign w_clk_last = r_clk_sync[NS-1];
  assign w_cs_last  = r_cs_sync[NS-1];
  assign w_dat_last = r_dat_sync[NS-1];

  // Synchronisers, edge detectors and the post-reset arming of chip select.
  // A CS that is already low when reset is released must first be seen high,
  // so r_warm waits until the synchroniser holds real pin samples.
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      r_clk_sync <= {NS{1'b0}};
      r_cs_sync  <= {NS{1'b1}};
      r_dat_sync <= {NS{1'b0}};
      r_warm     <= {WARM{1'b0}};
      r_armed    <= 1'b0;
      r_clk_d    <= 1'b0;
      r_cs_d     <= 1'b1;
      r_clk_rise <= 1'b0;
      r_cs_rise  <= 1'b0;
      r_cs_fall  <= 1'b0;
      r_dat_q    <= 1'b0;
    end else begin
      r_clk_sync <= {r_clk_sync[NS-2:0], spi_clk};
      r_cs_sync  <= {r_cs_sync[NS-2:0], spi_cs};
      r_dat_sync <= {r_dat_sync[NS-2:0], spi_dat};
      r_warm     <= {r_warm[WARM-2:0], 1'b1};
      r_armed    <= r_armed | (r_warm[WARM-1] & w_cs_last);
      r_clk_d    <= w_clk_last;
      r_cs_d     <= w_cs_last;
      r_clk_rise <= w_clk_last & ~r_clk_d;
      r_cs_rise  <= w_cs_last & ~r_cs_d;
      r_cs_fall  <= ~w_cs_last & r_cs_d & r_armed;
      r_dat_q    <= w_dat_last;
    end
  end

  // Frame FSM state, shift register and bit counter.
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      r_state <= ST_IDLE;
      r_sr    <= 15'h0000;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_nxt_state;
      r_sr    <= w_nxt_sr;
      r_cnt   <= w_nxt_cnt;
    end
  end

  assign w_sr_shift = {r_sr, r_dat_q};

  // Next-state logic; the counter wraps 15->0 on the 16th bit, which is the commit point.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_sr    = r_sr;
    w_nxt_cnt   = r_cnt;
    w_commit    = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_cs_fall) begin
          w_nxt_state = ST_SHIFT;
          w_nxt_sr    = 15'h0000;
          w_nxt_cnt   = 4'd0;
        end else begin
          w_nxt_state = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (r_clk_rise) begin
          w_nxt_sr  = w_sr_shift[14:0];
          w_nxt_cnt = r_cnt + 4'd1;
          w_commit  = (r_cnt == 4'd15);
        end else begin
          w_nxt_sr  = r_sr;
        end
        if (r_cs_rise) begin
          w_nxt_state = ST_IDLE;
          w_err       = (w_nxt_cnt != 4'd0);
        end else begin
          w_nxt_state = ST_SHIFT;
        end
      end
      default: begin
        w_nxt_state = ST_IDLE;
      end
    endcase
  end

  // Word commit, register bank and error accounting.
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      r_reg_wr    <= 1'b0;
      r_frame_err <= 1'b0;
      r_reg_adr   <= 4'd0;
      r_reg_dat   <= 12'h000;
      r_err_cnt   <= 8'h00;
      for (int k = 0; k < 16; k++) begin
        r_regs[k] <= REG_INIT;
      end
    end else begin
      r_reg_wr    <= w_commit;
      r_frame_err <= w_err;
      if (w_commit) begin
        r_reg_adr                 <= w_sr_shift[15:12];
        r_reg_dat                 <= w_sr_shift[11:0];
        r_regs[w_sr_shift[15:12]] <= w_sr_shift[11:0];
      end
      if (w_err && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  for (genvar k = 0; k < 16; k++) begin : g_flat
    assign regs_o[12*k +: 12] = r_regs[k];
  end

  assign reg_wr    = r_reg_wr;
  assign frame_err = r_frame_err;
  assign reg_adr   = r_reg_adr;
  assign reg_dat   = r_reg_dat;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_icx_spi_slave.sv
// Self-checking bench for icx_spi_slave: table of frames plus hand-written corner sequences,
// with a scoreboard of expected reg_wr / frame_err events including their exact cycle.
`timescale 1ns/1ps
module tb_icx_spi_slave;

  logic         wb_clk = 1'b0;
  logic         wb_rst = 1'b0;
  logic         spi_clk = 1'b0;
  logic         spi_cs = 1'b1;
  logic         spi_dat = 1'b0;
  logic         reg_wr;
  logic [3:0]   reg_adr;
  logic [11:0]  reg_dat;
  logic [191:0] regs_o;
  logic         frame_err;
  logic [7:0]   err_cnt;

  icx_spi_slave #(.NSYNC(2), .REG_INIT(12'h000)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .spi_clk(spi_clk), .spi_cs(spi_cs), .spi_dat(spi_dat),
    .reg_wr(reg_wr), .reg_adr(reg_adr), .reg_dat(reg_dat), .regs_o(regs_o),
    .frame_err(frame_err), .err_cnt(err_cnt)
  );

  always #5 wb_clk = ~wb_clk;

  typedef struct {
    bit          is_err;
    logic [3:0]  adr;
    logic [11:0] dat;
    int          cyc;
  } ev_t;

  typedef struct {
    logic [47:0] data;
    int          nbits;
    bit          same;
    int          chk_idx;
    logic [11:0] chk_val;
    logic [7:0]  chk_err;
  } vec_t;

  ev_t         sb[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [11:0] model_regs [16];
  logic [7:0]  model_err;

  always @(posedge wb_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [191:0] model_flat();
    logic [191:0] f;
    for (int k = 0; k < 16; k++) f[12*k +: 12] = model_regs[k];
    return f;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 16; k++) model_regs[k] = 12'h000;
    model_err = 8'h00;
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge wb_clk);
  endtask

  // Scoreboard consumer: every output strobe must match the next expected event.
  always @(negedge wb_clk) begin
    if (wb_rst) begin
      if (reg_wr) begin
        if (sb.size() == 0) begin
          check("unexpected_reg_wr", 192'd1, 192'd0);
        end else begin
          ev_t e;
          e = sb.pop_front();
          check("wr_kind", {191'd0, e.is_err}, 192'd0);
          check("wr_adr", {188'd0, reg_adr}, {188'd0, e.adr});
          check("wr_dat", {180'd0, reg_dat}, {180'd0, e.dat});
          check("wr_cycle", 192'(cyc), 192'(e.cyc));
        end
      end
      if (frame_err) begin
        if (sb.size() == 0) begin
          check("unexpected_frame_err", 192'd1, 192'd0);
        end else begin
          ev_t e;
          e = sb.pop_front();
          check("err_kind", {191'd0, e.is_err}, 192'd1);
          check("err_cycle", 192'(cyc), 192'(e.cyc));
        end
      end
    end
  end

  // Drives one CS-framed transfer of nb bits taken MSB first from d[47:...].
  task automatic drive_frame(input logic [47:0] d, input int nb, input bit same);
    logic [15:0] w;
    @(negedge wb_clk);
    spi_cs = 1'b0;
    wait_neg(6);
    for (int i = 0; i < nb; i++) begin
      spi_dat = d[47-i];
      wait_neg(6);
      spi_clk = 1'b1;
      if ((i % 16) == 15) begin
        w = d[62-i -: 16];
        sb.push_back('{1'b0, w[15:12], w[11:0], cyc + 4});
        model_regs[w[15:12]] = w[11:0];
      end
      if (same && (i == nb - 1)) spi_cs = 1'b1;
      wait_neg(6);
      spi_clk = 1'b0;
    end
    if (!same) begin
      wait_neg(6);
      spi_cs = 1'b1;
      if ((nb % 16) != 0) begin
        sb.push_back('{1'b1, 4'd0, 12'h000, cyc + 4});
        model_err = (model_err == 8'hFF) ? 8'hFF : model_err + 8'd1;
      end
    end
    wait_neg(10);
  endtask

  initial begin
    #800us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    vecs[0] = '{{16'h3ABC, 32'h0}, 16, 1'b0, 3, 12'hABC, 8'd0};
    vecs[1] = '{{16'h0001, 16'hF123, 16'h7FFF}, 48, 1'b0, 7, 12'hFFF, 8'd0};
    vecs[2] = '{{16'h5555, 32'h0}, 9, 1'b0, 5, 12'h000, 8'd1};
    vecs[3] = '{{16'h5555, 32'h0}, 16, 1'b0, 5, 12'h555, 8'd1};
    vecs[4] = '{{16'h2010, 32'h0}, 16, 1'b1, 2, 12'h010, 8'd1};

    model_reset();
    wait_neg(3);
    check("rst_regs", regs_o, 192'd0);
    check("rst_errcnt", {184'd0, err_cnt}, 192'd0);
    check("rst_strobes", {190'd0, reg_wr, frame_err}, 192'd0);
    check("rst_word", {176'd0, reg_adr, reg_dat}, 192'd0);
    wb_rst = 1'b1;
    wait_neg(12);

    for (int v = 0; v < 5; v++) begin
      drive_frame(vecs[v].data, vecs[v].nbits, vecs[v].same);
      check("vec_reg", {180'd0, regs_o[12*vecs[v].chk_idx +: 12]}, {180'd0, vecs[v].chk_val});
      check("vec_errcnt", {184'd0, err_cnt}, {184'd0, vecs[v].chk_err});
      check("vec_bank", regs_o, model_flat());
    end
    check("burst_reg0", {180'd0, regs_o[11:0]}, {180'd0, 12'h001});
    check("burst_reg15", {180'd0, regs_o[191:180]}, {180'd0, 12'h123});

    for (int n = 0; n < 300; n++) drive_frame({16'h1F00, 32'h0}, 5, 1'b0);
    check("sat_errcnt", {184'd0, err_cnt}, {184'd0, 8'hFF});
    drive_frame({16'h9ABC, 32'h0}, 16, 1'b0);
    check("sat_good_reg9", {180'd0, regs_o[119:108]}, {180'd0, 12'hABC});
    check("sat_errcnt_hold", {184'd0, err_cnt}, {184'd0, model_err});
    check("sat_bank", regs_o, model_flat());

    // Reset in the middle of a frame, released with CS still low.
    @(negedge wb_clk);
    spi_cs = 1'b0;
    wait_neg(6);
    for (int i = 0; i < 16; i++) begin
      if (i == 8) begin
        wb_rst = 1'b0;
        wait_neg(3);
        model_reset();
        wb_rst = 1'b1;
        wait_neg(2);
      end
      spi_dat = i[0];
      wait_neg(6);
      spi_clk = 1'b1;
      wait_neg(6);
      spi_clk = 1'b0;
    end
    wait_neg(6);
    spi_cs = 1'b1;
    wait_neg(12);
    check("rstmid_errcnt", {184'd0, err_cnt}, 192'd0);
    check("rstmid_bank", regs_o, 192'd0);
    drive_frame({16'hC5A5, 32'h0}, 16, 1'b0);
    check("rstmid_regC", {180'd0, regs_o[155:144]}, {180'd0, 12'h5A5});
    check("rstmid_after_bank", regs_o, model_flat());

    wait_neg(20);
    check("sb_drained", 192'(sb.size()), 192'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
